// File: rtl/jtag_chain_scan_master.sv
// jtag_chain_scan_master: JTAG host driving IR/DR scans into one TAP of a daisy chain with ones-padding for the others
module jtag_chain_scan_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 64,
    parameter int PAD_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_ir,
    input  logic               cmd_tlr,
    input  logic [6:0]         cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    input  logic [PAD_W-1:0]   cmd_pre,
    input  logic [PAD_W-1:0]   cmd_post,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    input  logic               jtag_tdo
);
    typedef enum logic [2:0] {TLR, IDLE, SELECT, SHIFT, EXIT, RESP} state_t;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [6:0] MAX7 = 7'(MAX_LEN);
    state_t state;
    logic [DW-1:0] div;
    logic [9:0] cnt, nxt, tot, d_lo, d_hi;
    logic [6:0] len, len_c;
    logic [MAX_LEN-1:0] dsr, dsr_n, rsp_sr;
    logic ir, tlr_rsp, active, tick, fall, in_i, in_n;
    assign active = state inside {TLR, SELECT, SHIFT, EXIT};
    assign tick = div == DW'(CLK_DIV - 1);
    assign fall = active && tick && jtag_tck;
    assign nxt = cnt + 10'd1;
    assign in_i = cnt >= d_lo && cnt < d_hi;
    assign in_n = nxt >= d_lo && nxt < d_hi;
    assign dsr_n = in_i ? dsr >> 1 : dsr;
    assign len_c = cmd_len > MAX7 ? MAX7 : cmd_len;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
            div <= '0;
            cnt <= '0;
            tot <= '0;
            d_lo <= '0;
            d_hi <= '0;
            len <= '0;
            ir <= 1'b0;
            tlr_rsp <= 1'b0;
            dsr <= '0;
            rsp_sr <= '0;
            jtag_tck <= 1'b0;
            jtag_tms <= 1'b1;
            jtag_tdi <= 1'b1;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            busy <= 1'b1;
        end else begin
            div <= (active && !tick) ? div + 1'b1 : '0;
            if (active && tick && !jtag_tck) jtag_tck <= 1'b1;
            if (fall) begin
                jtag_tck <= 1'b0;
                cnt <= nxt;
            end
            case (state)
                TLR: if (fall) begin
                    jtag_tms <= cnt < 10'd4;
                    if (cnt == 10'd5) begin
                        cnt <= '0;
                        jtag_tms <= 1'b0;
                        tlr_rsp <= 1'b0;
                        if (tlr_rsp) begin
                            state <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            state <= IDLE;
                            cmd_ready <= 1'b1;
                            busy <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                    jtag_tms <= 1'b0;
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy <= 1'b1;
                        cnt <= '0;
                        jtag_tdi <= 1'b1;
                        ir <= cmd_ir;
                        len <= len_c;
                        dsr <= cmd_data;
                        rsp_sr <= '0;
                        d_lo <= 10'(cmd_post);
                        d_hi <= 10'(cmd_post) + 10'(len_c);
                        tot <= 10'(cmd_post) + 10'(len_c) + 10'(cmd_pre);
                        if (cmd_tlr) begin
                            state <= TLR;
                            tlr_rsp <= 1'b1;
                            jtag_tms <= 1'b1;
                        end else if (len_c == 7'd0) begin
                            state <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data <= '0;
                        end else begin
                            state <= SELECT;
                            jtag_tms <= 1'b1;
                        end
                    end
                end
                SELECT: if (fall) begin
                    jtag_tms <= ir && cnt == 10'd0;
                    if (cnt == (ir ? 10'd3 : 10'd2)) begin
                        state <= SHIFT;
                        cnt <= '0;
                        jtag_tms <= tot == 10'd1;
                        jtag_tdi <= d_lo == 10'd0 ? dsr[0] : 1'b1;
                    end
                end
                SHIFT: if (fall) begin
                    dsr <= dsr_n;
                    if (in_i) rsp_sr <= {jtag_tdo, rsp_sr[MAX_LEN-1:1]};
                    if (cnt == tot - 10'd1) begin
                        state <= EXIT;
                        cnt <= '0;
                        jtag_tms <= 1'b1;
                        jtag_tdi <= 1'b1;
                    end else begin
                        jtag_tms <= nxt == tot - 10'd1;
                        jtag_tdi <= in_n ? dsr_n[0] : 1'b1;
                    end
                end
                EXIT: if (fall) begin
                    jtag_tms <= 1'b0;
                    if (cnt == 10'd1) begin
                        state <= RESP;
                        cnt <= '0;
                        rsp_valid <= 1'b1;
                        rsp_data <= rsp_sr >> (MAX7 - len);
                    end
                end
                RESP: if (rsp_ready) begin
                    state <= IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy <= 1'b0;
                end
                default: state <= TLR;
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_chain_scan_master.sv
// tb_jtag_chain_scan_master: scoreboard bench with a behavioural multi-TAP chain on the JTAG pins
module tb_jtag_chain_scan_master;
    typedef enum {TLR_S, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR, SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR} tap_t;
    logic clk = 1'b0;
    logic rst_n, cmd_valid, cmd_ready, cmd_ir, cmd_tlr, rsp_valid, rsp_ready, busy;
    logic jtag_tck, jtag_tms, jtag_tdi;
    logic jtag_tdo = 1'b1;
    logic [6:0] cmd_len;
    logic [63:0] cmd_data, rsp_data;
    logic [7:0] cmd_pre, cmd_post;
    int checks = 0, errors = 0, nrsp = 0, ntck = 0, cyc = 0;
    logic [63:0] exp_q[$];
    logic overlap = 1'b0;
    logic [1023:0] tms_log, tdi_log, sr;
    int rise_cyc[16];
    int slen = 0, ntaps = 1;
    int ir_len[3], dr_len[3];
    logic [63:0] ir_cap[3], dr_cap[3], ir_upd[3], dr_upd[3];
    tap_t ts = TLR_S;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    jtag_chain_scan_master #(.CLK_DIV(2), .MAX_LEN(64), .PAD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_tlr(cmd_tlr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .cmd_pre(cmd_pre), .cmd_post(cmd_post), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .busy(busy), .jtag_tck(jtag_tck), .jtag_tms(jtag_tms),
        .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic tap_t nxt_tap(input tap_t s, input logic m);
        case (s)
            TLR_S: return m ? TLR_S : RTI;
            RTI:   return m ? SDR : RTI;
            SDR:   return m ? SIR : CDR;
            CDR:   return m ? E1DR : SHDR;
            SHDR:  return m ? E1DR : SHDR;
            E1DR:  return m ? UDR : PDR;
            PDR:   return m ? E2DR : PDR;
            E2DR:  return m ? UDR : SHDR;
            UDR:   return m ? SDR : RTI;
            SIR:   return m ? TLR_S : CIR;
            CIR:   return m ? E1IR : SHIR;
            SHIR:  return m ? E1IR : SHIR;
            E1IR:  return m ? UIR : PIR;
            PIR:   return m ? E2IR : PIR;
            E2IR:  return m ? UIR : SHIR;
            default: return m ? SDR : RTI;
        endcase
    endfunction

    // TAP 0 sits next to the TDO pin, so it occupies the low bits of the chain register
    task automatic capture(input bit is_ir);
        int p, l;
        logic [63:0] c;
        p = 0;
        sr = '0;
        for (int i = 0; i < ntaps; i++) begin
            l = is_ir ? ir_len[i] : dr_len[i];
            c = is_ir ? ir_cap[i] : dr_cap[i];
            for (int b = 0; b < l; b++) sr[p+b] = c[b];
            p += l;
        end
        slen = p;
    endtask

    task automatic update(input bit is_ir);
        int p, l;
        logic [63:0] v;
        p = 0;
        for (int i = 0; i < ntaps; i++) begin
            l = is_ir ? ir_len[i] : dr_len[i];
            v = '0;
            for (int b = 0; b < l; b++) v[b] = sr[p+b];
            if (is_ir) ir_upd[i] = v; else dr_upd[i] = v;
            p += l;
        end
    endtask

    always @(posedge jtag_tck) begin
        if (ntck < 1024) begin
            tms_log[ntck] = jtag_tms;
            tdi_log[ntck] = jtag_tdi;
        end
        if (ntck < 16) rise_cyc[ntck] = cyc;
        ntck++;
        case (ts)
            CDR, CIR: capture(ts == CIR);
            SHDR, SHIR: begin
                sr = sr >> 1;
                sr[slen-1] = jtag_tdi;
            end
            UDR, UIR: update(ts == UIR);
            default: ;
        endcase
        ts = nxt_tap(ts, jtag_tms);
    end

    always @(negedge jtag_tck) jtag_tdo = (ts == SHDR || ts == SHIR) ? sr[0] : 1'b1;

    always @(negedge clk) begin
        if (cmd_ready && rsp_valid) overlap = 1'b1;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("spurious_rsp", 64'(rsp_valid), 64'd0);
            else begin
                chk("rsp_data", rsp_data, exp_q.pop_front());
                nrsp++;
            end
        end
    end

    task automatic send(input logic ir, input logic tlr, input logic [6:0] len, input logic [63:0] data,
                        input logic [7:0] pre, input logic [7:0] post, input logic [63:0] exp);
        int t;
        ntck = 0;
        exp_q.push_back(exp);
        cmd_ir = ir; cmd_tlr = tlr; cmd_len = len; cmd_data = data; cmd_pre = pre; cmd_post = post;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
        chk("accept", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        do begin @(negedge clk); t++; end while (!cmd_ready && t < 2000);
        chk("ready", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] d;
        int n, t;
        logic stable;
        rst_n = 1'b1; cmd_valid = 1'b0; cmd_ir = 1'b0; cmd_tlr = 1'b0; cmd_len = '0;
        cmd_data = '0; cmd_pre = '0; cmd_post = '0; rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tck", 64'(jtag_tck), 64'd0);
        chk("rst_tms_tdi", {62'd0, jtag_tms, jtag_tdi}, 64'd3);
        chk("rst_ready_valid_busy", {61'd0, cmd_ready, rsp_valid, busy}, 64'd1);
        chk("rst_rsp_data", rsp_data, 64'd0);
        ntck = 0;
        rst_n = 1'b1;
        wait_ready();
        chk("rst_tck_count", 64'(ntck), 64'd6);
        chk("rst_tms_seq", 64'(tms_log[5:0]), 64'h1f);
        chk("tck_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'd4);
        chk("idle_tck_low_busy", {62'd0, jtag_tck, busy}, 64'd0);

        ntaps = 1; ir_len[0] = 5; ir_cap[0] = 64'h01;
        rsp_ready = 1'b0;
        send(1'b1, 1'b0, 7'd5, 64'h15, 8'd0, 8'd0, 64'h01);
        t = 0;
        while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
        chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        d = rsp_data; n = ntck; stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            stable &= rsp_valid && rsp_data == d && !cmd_ready && !jtag_tck;
        end
        chk("bp_stable", 64'(stable), 64'd1);
        chk("bp_no_tck", 64'(ntck), 64'(n));
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        chk("bp_idle_next", {62'd0, cmd_ready, rsp_valid}, 64'd2);
        rsp_ready = 1'b1;
        chk("ir_tck_count", 64'(ntck), 64'd11);
        chk("ir_tms_seq", 64'(tms_log[10:0]), 64'h303);
        chk("ir_tdi_bits", 64'(tdi_log[8:4]), 64'h15);
        chk("ir_updated", ir_upd[0], 64'h15);

        ntaps = 3;
        dr_len[0] = 1; dr_len[1] = 32; dr_len[2] = 1;
        dr_cap[0] = 64'd0; dr_cap[1] = 64'h1BA01477; dr_cap[2] = 64'd0;
        send(1'b0, 1'b0, 7'd32, 64'hCAFEF00D, 8'd1, 8'd1, 64'h1BA01477);
        wait_ready();
        chk("chain_tck_count", 64'(ntck), 64'd39);
        chk("chain_tms_seq", 64'(tms_log[38:0]), 64'h30_0000_0001);
        chk("chain_tdi_pads", {62'd0, tdi_log[3], tdi_log[36]}, 64'd3);
        chk("chain_tdi_data", 64'(tdi_log[35:4]), 64'hCAFEF00D);
        chk("chain_target_dr", dr_upd[1], 64'hCAFEF00D);
        chk("chain_bypass_dr", {dr_upd[0][31:0], dr_upd[2][31:0]}, {32'd1, 32'd1});

        send(1'b0, 1'b0, 7'd0, 64'hFFFF, 8'd2, 8'd2, 64'd0);
        wait_ready();
        chk("len0_no_tck", 64'(ntck), 64'd0);

        ntaps = 1; dr_len[0] = 64; dr_cap[0] = 64'hA5A5_0F0F_1234_8001;
        send(1'b0, 1'b0, 7'd100, 64'hDEAD_BEEF_0123_4567, 8'd0, 8'd0, 64'hA5A5_0F0F_1234_8001);
        wait_ready();
        chk("clamp_tck_count", 64'(ntck), 64'd69);
        chk("clamp_dr", dr_upd[0], 64'hDEAD_BEEF_0123_4567);

        send(1'b1, 1'b1, 7'd5, 64'h1F, 8'd3, 8'd3, 64'd0);
        wait_ready();
        chk("tlr_tck_count", 64'(ntck), 64'd6);
        chk("tlr_tms_seq", 64'(tms_log[5:0]), 64'h1f);
        chk("tlr_tap_rti", 64'(ts == RTI), 64'd1);

        ntaps = 3;
        send(1'b0, 1'b0, 7'd32, 64'h1234_5678, 8'd1, 8'd1, 64'h1BA01477);
        t = 0;
        while (ntck < 14 && t < 2000) begin @(negedge clk); t++; end
        chk("midshift_reached", 64'(ntck), 64'd14);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("async_rst_pins", {61'd0, jtag_tck, jtag_tms, jtag_tdi}, 64'd3);
        chk("async_rst_ctrl", {61'd0, cmd_ready, rsp_valid, busy}, 64'd1);
        exp_q.delete();
        ntck = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready();
        chk("rerun_tck_count", 64'(ntck), 64'd6);
        chk("rerun_tms_seq", 64'(tms_log[5:0]), 64'h1f);
        repeat (40) @(negedge clk);
        chk("rsp_count", 64'(nrsp), 64'd5);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("ready_valid_excl", 64'(overlap), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/jtag_chain_scan_master.md
Name: jtag_chain_scan_master

Overview:
Host-side JTAG initiator that drives a multi-TAP daisy chain through its TCK/TMS/TDI pins and captures TDO. It accepts IR-scan or DR-scan commands for one selected TAP and walks the IEEE 1149.1 TAP state machine. It pads the shift with ones for the TAPs before and after the target, and returns the selected TAP's captured bits. It sits between a debug/test command source and the external chain, at the opposite end of the wire from the per-device chain controllers.

Parameters:
CLK_DIV, 2, TCK half-period in clk cycles (>=1); TCK period = 2*CLK_DIV clk
MAX_LEN, 64, max selected-TAP shift length in bits
PAD_W, 8, width of pre/post padding counts

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_ir  in  1  1=IR scan, 0=DR scan
cmd_tlr  in  1  1=Test-Logic-Reset command (other fields ignored)
cmd_len  in  7  selected-TAP bit count
cmd_data  in  MAX_LEN  TDI data for selected TAP, LSB shifted first
cmd_pre  in  PAD_W  pad bits for TAPs between TDI pin and target
cmd_post  in  PAD_W  pad bits for TAPs between target and TDO pin
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_data  out  MAX_LEN  captured target bits, LSB first-captured; bits >= len are 0
busy  out  1  high whenever FSM is not IDLE
jtag_tck  out  1  TCK
jtag_tms  out  1  TMS
jtag_tdi  out  1  TDI
jtag_tdo  in  1  TDO from chain end

Behaviour:
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=1, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1. FSM enters TLR.
- TCK timing: TMS and TDI are updated only on the clk edge that drives TCK low. jtag_tdo is sampled on the clk edge that drives TCK high→low, i.e. at the end of the high phase. TCK idles low.
- FSM states: TLR, IDLE, SELECT, SHIFT, EXIT, RESP.
- TLR: 5 TCKs with TMS=1, then 1 TCK with TMS=0 (chain in Run-Test/Idle), then goes to IDLE. Entered on reset and on a cmd_tlr command. A cmd_tlr command also produces a RESP with rsp_data=0.
- IDLE: TCK held low, TMS=0, cmd_ready=1, busy=0. Accept on cmd_valid. All cmd fields are latched at acceptance.
  - cmd_len>MAX_LEN is clamped to MAX_LEN.
  - cmd_len=0: go straight to RESP with rsp_data=0 and no TCK pulses.
- SELECT: the TMS sequence is 1,0,0 for DR and 1,1,0,0 for IR, giving Shift-xR. DR takes 3 TCKs; IR takes 4.
- SHIFT: L = post + len + pre TCKs (10-bit counter, max 574). TMS=0 on all but the last TCK; TMS=1 on the last (exit to Exit1).
  - TDI order: post ones, then cmd_data[0..len-1], then pre ones.
  - TDO capture: the first post samples are discarded, the next len samples go into rsp_data[0..len-1], and the last pre samples are discarded.
- EXIT: TMS 1 (Update-xR), then 0 (Run-Test/Idle): 2 TCKs, then RESP.
- Total TCKs per scan: DR = L+5, IR = L+6.
- RESP: rsp_valid=1 with rsp_data stable until rsp_ready, then IDLE. cmd_ready=0 throughout. rsp_valid and cmd_ready are never high together.
- Async reset mid-operation: outputs go immediately to reset values, the in-flight command and response are dropped, and the TLR sequence reruns before cmd_ready rises.

Test Plan:
- Reset release, CLK_DIV=2 → exactly 6 TCKs (TMS 1,1,1,1,1,0), TCK period 4 clk, then cmd_ready=1 with TCK low.
- Single TAP, IR, len=5, data=0x15, pre=post=0, TDO model = 5-bit IR capturing 0b00001 → TMS pattern 1,1,0,0,0,0,0,0,1,1,0. TDI bits 1,0,1,0,1. rsp_data=0x01. TAP model IR=0x15.
- 3-TAP chain, DR, len=32, pre=1, post=1 (bypass TAPs), target IDCODE 0x1BA01477 → 34 shift TCKs, TDI stream starts and ends with 1, rsp_data=0x1BA01477.
- Backpressure: hold rsp_ready=0 for 20 clk after rsp_valid → rsp_valid and rsp_data stable, cmd_ready=0, no TCK edges. One-cycle rsp_ready → IDLE next cycle.
- Edge lengths: cmd_len=0 → RESP with no TCK pulse. cmd_len=100 → clamped to 64 shift bits. cmd_tlr → 6 TCKs, rsp_data=0.
- Assert rst_n low mid-SHIFT (bit 10 of 32) → next clk TCK=0, TMS=1, rsp_valid=0. After release, the TLR sequence reruns and no response is produced for the dropped command.
